camera_frame_capture: RTL
=========================

# camera_frame_capture

Upstream stage of the SPI frame readout path: samples the OV7670-style parallel camera bus (asynchronous PCLK/VSYNC/HREF/D[7:0]) in the 48 MHz system domain. It keeps the luma byte of each YUV422 pixel, thresholds it to 1 bit and packs 8 pixels per byte. It writes one 320×240 binary frame (9600 bytes) into SPRAM, then raises `buffer_ready` and holds it until the SPI slave pulses `frame_read_complete`. Single buffer: frames arriving while the buffer is held are skipped.

## Interface
- `H_PIXELS`, default 320: pixels per line kept; must be a multiple of 8.
- `V_LINES`, default 240: lines per frame kept.
- `THRESHOLD`, default 8'd128: luma compare value.
- `clk` in 1: system clock, 48 MHz.
- `reset` in 1: synchronous, active-high.
- `cam_pclk` in 1: camera pixel clock, async, ≤ 8 MHz.
- `cam_vsync` in 1: async, high between frames.
- `cam_href` in 1: async, high while a line's bytes are valid.
- `cam_data` in 8: async, stable at `cam_pclk` rising edge.
- `spram_wr_addr` out 17: byte address 0..9599.
- `spram_wr_data` out 8: packed pixels, first pixel in bit 7.
- `spram_wr_en` out 1: one-cycle write strobe.
- `buffer_ready` out 1: a complete frame is in SPRAM.
- `frame_read_complete` in 1: one-cycle pulse from the SPI slave.
- `frame_error` out 1: one-cycle pulse when a frame is dropped for short byte count.

## Operation
- Input sync: `cam_pclk`, `cam_vsync` and `cam_href` pass through 2 flops, then 1 edge-detect flop. `cam_data` is delayed by the same depth, so the data sampled on a detected PCLK rise is the data present at that PCLK edge.
- States:
  - IDLE → WAIT_VS when `vsync` is high.
  - WAIT_VS → CAPTURE on `vsync` falling. On entry, clear column, row, byte phase, shift register and address.
  - CAPTURE → READY on `vsync` rising with address count == H_PIXELS·V_LINES/8.
  - CAPTURE → IDLE on `vsync` rising with a short count; pulse `frame_error`.
  - READY → IDLE on `frame_read_complete`.
- Byte phase: toggles on each PCLK rise while `href` is high. Phase 0 is the Y byte and is the only one used. Phase clears on `href` falling.
- Pixel bit = (Y ≥ THRESHOLD). The bit shifts into the LSB of an 8-bit register. Column count increments per Y byte.
- Every 8th kept pixel: assert `spram_wr_en` with the packed byte, then increment the address after the strobe.
- On `href` falling: if column count > 0, increment row and clear column.
- Pixels with column ≥ H_PIXELS and lines with row ≥ V_LINES are discarded. No write is issued for them and the address does not advance past 9599.
- `frame_read_complete` outside READY is ignored. VSYNC edges in READY or IDLE are ignored.
- `vsync` rising in the same cycle as a PCLK rise: the VSYNC edge wins and the pixel is discarded.
- Reset mid-frame: state returns to IDLE, all outputs take reset values, and the partial frame is abandoned. Capture resumes at the next full VSYNC cycle.

## Timing
- Reset values:
  - `spram_wr_addr` = 0
  - `spram_wr_data` = 0
  - `spram_wr_en` = 0
  - `buffer_ready` = 0
  - `frame_error` = 0
  - state = IDLE
- Latency: `cam_pclk` rising at the pin → `spram_wr_en` high is 4 clk cycles for the 8th pixel of a byte. Address and data are valid in the same cycle as the strobe.
- `buffer_ready` goes high 1 cycle after the detected `vsync` rise. It falls 1 cycle after `frame_read_complete` is sampled.
- Successive writes are at least 6 clk apart. SPRAM accepts a write every cycle, so no back-pressure exists.

## Configuration
- `CAM_INVERT_EN` defined: pixel bit = (Y < THRESHOLD), so dark pixels read as 1 (line-following target).
- `CAM_INVERT_EN` undefined: pixel bit = (Y ≥ THRESHOLD).
- Nothing else changes.

## Structure
- Package `cam_pkg`:
  - `H_PIXELS`, `V_LINES`
  - `FRAME_BYTES` = 9600
  - `SPRAM_ADDR_W` = 17
  - `cap_state_t` enum {IDLE, WAIT_VS, CAPTURE, READY}
- Sub-module `edge_sync`: 2-flop synchronizer plus edge-detect flop, with `rise`/`fall`/`level` outputs. Instantiated three times (PCLK, VSYNC, HREF).
- The data delay line lives in the top module.

## Test plan
- Full frame, Y alternating 0x00/0xFF per pixel, 4 MHz PCLK → 9600 writes, addresses 0..9599, every byte 0x55. `buffer_ready` rises after VSYNC; no `frame_error`.
- Second frame sent while `buffer_ready` = 1 → zero writes. Pulse `frame_read_complete` → `buffer_ready` = 0 next cycle, and the next frame is captured.
- Frame of only 100 lines → `frame_error` pulses once, `buffer_ready` stays 0, state returns to IDLE.
- Lines of 330 pixels and 250 lines → exactly 9600 writes, last address 9599.
- `reset` asserted mid-line 57 → all outputs 0 next cycle. No writes until a new VSYNC high→low. The next frame starts at address 0.
- `CAM_INVERT_EN` build, all Y = 0x10 → every byte 0xFF. Default build → every byte 0x00.

Source files
------------

// File: rtl/camera_frame_capture_pkg.sv
// Shared types and default geometry for the camera frame capture path.
package cam_pkg;
    localparam int H_PIXELS     = 320;
    localparam int V_LINES      = 240;
    localparam int FRAME_BYTES  = H_PIXELS * V_LINES / 8;
    localparam int SPRAM_ADDR_W = 17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        READY   = 2'd3
    } cap_state_t;
endpackage

// File: rtl/camera_frame_capture_edge_sync.sv
// Two-flop synchronizer for an asynchronous camera line, plus one history flop
// that turns the synchronized level into single-cycle rise/fall strobes.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign level = sync2_q;
    assign rise  = sync2_q & ~prev_q;
    assign fall  = ~sync2_q & prev_q;
endmodule

// File: rtl/camera_frame_capture.sv
// Captures one thresholded, 8-pixels-per-byte luma frame from a parallel camera into SPRAM.
// Define CAM_INVERT_EN to make dark pixels read as 1.
module camera_frame_capture #(
    parameter int          H_PIXELS  = cam_pkg::H_PIXELS,
    parameter int          V_LINES   = cam_pkg::V_LINES,
    parameter logic [7:0]  THRESHOLD = 8'd128
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cam_pclk,
    input  logic                             cam_vsync,
    input  logic                             cam_href,
    input  logic [7:0]                       cam_data,
    output logic [cam_pkg::SPRAM_ADDR_W-1:0] spram_wr_addr,
    output logic [7:0]                       spram_wr_data,
    output logic                             spram_wr_en,
    output logic                             buffer_ready,
    input  logic                             frame_read_complete,
    output logic                             frame_error,
    output logic [1:0]                       debug_state
);
    import cam_pkg::*;

    localparam int COL_W = $clog2(H_PIXELS + 1);
    localparam int ROW_W = $clog2(V_LINES + 1);
    localparam logic [COL_W-1:0]        H_MAX     = COL_W'(H_PIXELS);
    localparam logic [ROW_W-1:0]        V_MAX     = ROW_W'(V_LINES);
    localparam logic [SPRAM_ADDR_W-1:0] FRAME_CNT = SPRAM_ADDR_W'(H_PIXELS * V_LINES / 8);

    logic pclk_level, pclk_rise, pclk_fall;
    logic vs_level, vs_rise, vs_fall;
    logic href_level, href_rise, href_fall;

    edge_sync u_pclk_sync (.clk(clk), .reset(reset), .async_in(cam_pclk),
                           .level(pclk_level), .rise(pclk_rise), .fall(pclk_fall));
    edge_sync u_vs_sync   (.clk(clk), .reset(reset), .async_in(cam_vsync),
                           .level(vs_level), .rise(vs_rise), .fall(vs_fall));
    edge_sync u_href_sync (.clk(clk), .reset(reset), .async_in(cam_href),
                           .level(href_level), .rise(href_rise), .fall(href_fall));

    logic unused_sync;
    assign unused_sync = &{1'b0, pclk_level, pclk_fall, href_rise};

    // Data is delayed as deep as the PCLK path so a detected rise sees the byte
    // that was on the bus at that PCLK edge.
    logic [7:0] data_d1, data_d2, data_d3;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_d1 <= '0;
            data_d2 <= '0;
            data_d3 <= '0;
        end else begin
            data_d1 <= cam_data;
            data_d2 <= data_d1;
            data_d3 <= data_d2;
        end
    end

    logic pix_bit;
`ifdef CAM_INVERT_EN
    assign pix_bit = (data_d3 < THRESHOLD);
`else
    assign pix_bit = (data_d3 >= THRESHOLD);
`endif

    cap_state_t                state_q, state_d;
    logic [COL_W-1:0]          col_q;
    logic [ROW_W-1:0]          row_q;
    logic                      phase_q;
    logic [7:0]                shift_q;
    logic [SPRAM_ADDR_W-1:0]   addr_q;
    logic                      pend_q;
    logic [SPRAM_ADDR_W-1:0]   addr_total;

    // A byte still waiting in the write stage counts toward the frame total.
    assign addr_total = addr_q + SPRAM_ADDR_W'(pend_q);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vs_level) state_d = WAIT_VS;
            WAIT_VS: if (vs_fall)  state_d = CAPTURE;
            CAPTURE: if (vs_rise)  state_d = (addr_total == FRAME_CNT) ? READY : IDLE;
            READY:   if (frame_read_complete) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign buffer_ready = (state_q == READY);
    assign debug_state  = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q         <= '0;
            row_q         <= '0;
            phase_q       <= 1'b0;
            shift_q       <= '0;
            addr_q        <= '0;
            pend_q        <= 1'b0;
            spram_wr_addr <= '0;
            spram_wr_data <= '0;
            spram_wr_en   <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            spram_wr_en <= 1'b0;
            frame_error <= 1'b0;

            if (pend_q) begin
                spram_wr_en   <= 1'b1;
                spram_wr_data <= shift_q;
                spram_wr_addr <= addr_q;
                addr_q        <= addr_q + 1'b1;
                pend_q        <= 1'b0;
            end

            if (state_q == WAIT_VS && vs_fall) begin
                col_q   <= '0;
                row_q   <= '0;
                phase_q <= 1'b0;
                shift_q <= '0;
                addr_q  <= '0;
                pend_q  <= 1'b0;
            end else if (state_q == CAPTURE) begin
                if (vs_rise) begin
                    // Frame boundary takes priority; a coincident pixel is dropped.
                    frame_error <= (addr_total != FRAME_CNT);
                end else begin
                    if (pclk_rise && href_level) begin
                        phase_q <= ~phase_q;
                        if (!phase_q && col_q < H_MAX && row_q < V_MAX) begin
                            shift_q <= {shift_q[6:0], pix_bit};
                            col_q   <= col_q + 1'b1;
                            if (col_q[2:0] == 3'd7) pend_q <= 1'b1;
                        end
                    end
                    if (href_fall) begin
                        phase_q <= 1'b0;
                        if (col_q != '0) begin
                            col_q <= '0;
                            if (row_q < V_MAX) row_q <= row_q + 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule
